// File: rtl/conv_enc_k4.sv
// conv_enc_k4 -- rate-1/2, constraint-length-4 convolutional encoder.
//
// One information bit is accepted per in_valid/in_ready handshake and one
// registered 2-bit code symbol is produced per encoded bit:
//    out_pair[1] = parity({cur, sr[2], sr[1], sr[0]} & G0)
//    out_pair[0] = parity({cur, sr[2], sr[1], sr[0]} & G1)
// where sr[2] is the most recent previous bit.
//
// Configuration macro: CONV_ENC_TAIL_EN
//    defined   : every frame is terminated by three zero tail bits (TAIL
//                state); the third tail symbol carries out_last and the
//                trellis is back in state 0 afterwards.
//    undefined : no tail; out_last follows in_last on the data symbol and
//                the history register is cleared when in_last is accepted.
module conv_enc_k4 #(
   parameter logic [3:0] G0 = 4'b1111,
   parameter logic [3:0] G1 = 4'b1101
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_bit,
   input  logic       in_last,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [1:0] out_pair,
   output logic       out_last
);

   // Both generators must tap the current bit, otherwise the code is not
   // a proper constraint-length-4 code and the decoder trellis is wrong.
   generate
      if (!(G0[3] && G1[3])) begin : g_bad_generator
         $error("conv_enc_k4: G0[3] and G1[3] must both be 1");
      end
   endgenerate

   // Even/odd parity of a 4-bit tapped window.
   function automatic logic f_parity4(input logic [3:0] i_v);
      return ^i_v;
   endfunction

   // Registered state shared by both build variants.
   logic [2:0] r_sr;
   logic       r_out_valid;
   logic [1:0] r_out_pair;
   logic       r_out_last;

   // Control decoded for the current cycle.
   logic       w_slot_free;   // output register can take a symbol this cycle
   logic       w_in_ready;
   logic       w_accept;      // an input bit is consumed this cycle
   logic       w_load;        // a symbol (data or tail) is produced this cycle
   logic       w_cur;         // bit being encoded
   logic       w_sym_last;    // produced symbol closes the frame
   logic       w_clear_sr;    // history is zeroed instead of shifted
   logic [3:0] w_win;
   logic [1:0] w_sym;

   assign w_slot_free = !r_out_valid || out_ready;

`ifdef CONV_ENC_TAIL_EN
   typedef enum logic {
      ST_DATA = 1'b0,
      ST_TAIL = 1'b1
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [1:0] r_tail_cnt;
   logic [1:0] w_tail_cnt_nxt;

   // FSM state and tail counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_DATA;
         r_tail_cnt <= 2'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_tail_cnt <= w_tail_cnt_nxt;
      end
   end

   // Next-state and per-cycle control: DATA encodes input bits, TAIL
   // pushes three zero bits through whenever the output slot is free.
   always_comb begin
      w_state_nxt    = r_state;
      w_tail_cnt_nxt = r_tail_cnt;
      w_in_ready     = 1'b0;
      w_accept       = 1'b0;
      w_load         = 1'b0;
      w_cur          = 1'b0;
      w_sym_last     = 1'b0;
      w_clear_sr     = 1'b0;
      case (r_state)
         ST_DATA: begin
            w_in_ready = w_slot_free;
            w_accept   = in_valid && w_slot_free;
            w_load     = w_accept;
            w_cur      = in_bit;
            if (w_accept && in_last) begin
               w_state_nxt    = ST_TAIL;
               w_tail_cnt_nxt = 2'd0;
            end else begin
               w_state_nxt    = ST_DATA;
            end
         end
         ST_TAIL: begin
            w_in_ready = 1'b0;
            w_cur      = 1'b0;
            w_load     = w_slot_free;
            if (w_slot_free) begin
               if (r_tail_cnt == 2'd2) begin
                  // third tail symbol: close the frame, trellis is at 0 now
                  w_sym_last     = 1'b1;
                  w_state_nxt    = ST_DATA;
                  w_tail_cnt_nxt = 2'd0;
               end else begin
                  w_tail_cnt_nxt = r_tail_cnt + 2'd1;
               end
            end else begin
               // downstream stalled: hold the tail position
               w_tail_cnt_nxt = r_tail_cnt;
            end
         end
         default: begin
            w_state_nxt    = ST_DATA;
            w_tail_cnt_nxt = 2'd0;
         end
      endcase
   end
`else
   // Unterminated framing: every symbol is a data symbol; the history is
   // zeroed on the last bit so the next frame still starts in state 0.
   always_comb begin
      w_in_ready = w_slot_free;
      w_accept   = in_valid && w_slot_free;
      w_load     = w_accept;
      w_cur      = in_bit;
      w_sym_last = 1'b0;
      w_clear_sr = 1'b0;
      if (w_accept) begin
         w_sym_last = in_last;
         w_clear_sr = in_last;
      end else begin
         w_sym_last = 1'b0;
         w_clear_sr = 1'b0;
      end
   end
`endif

   // Encoding window, current bit in the MSB, newest history bit next.
   assign w_win = {w_cur, r_sr};
   assign w_sym = {f_parity4(w_win & G0), f_parity4(w_win & G1)};

   // History register: shifts only when a symbol is actually produced, so
   // it holds under back-pressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sr <= 3'b000;
      end else if (w_load) begin
         if (w_clear_sr) begin
            r_sr <= 3'b000;
         end else begin
            r_sr <= {w_cur, r_sr[2:1]};
         end
      end else begin
         r_sr <= r_sr;
      end
   end

   // Output register: loads when a symbol is produced (the slot is free by
   // construction), otherwise drains on out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_pair  <= 2'b00;
         r_out_last  <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_pair  <= w_sym;
         r_out_last  <= w_sym_last;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= r_out_valid;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = r_out_valid;
   assign out_pair  = r_out_pair;
   assign out_last  = r_out_last;

endmodule

// File: tb/tb_conv_enc_k4.sv
// Self-checking bench for conv_enc_k4: directed vector tables for reset,
// single-bit, three-bit and back-pressure cases, then random traffic
// checked against a convolution-sum reference model.
module tb_conv_enc_k4;

   localparam logic [3:0] G0 = 4'b1111;
   localparam logic [3:0] G1 = 4'b1101;
`ifdef CONV_ENC_TAIL_EN
   localparam bit TAIL_EN = 1'b1;
`else
   localparam bit TAIL_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_bit = 1'b0;
   logic       in_last = 1'b0;
   logic       out_ready = 1'b0;
   logic       in_ready;
   logic       out_valid;
   logic [1:0] out_pair;
   logic       out_last;

   conv_enc_k4 #(.G0(G0), .G1(G1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bit    (in_bit),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pair  (out_pair),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state: bits of the current frame (tail zeros appended
   // as they are encoded), expected symbols {pair,last} in flight, whether
   // the output register should hold a symbol, and tail bits still owed.
   bit         fb[$];
   logic [2:0] exp_q[$];
   bit         mv = 1'b0;
   int         tail_pending = 0;

   typedef struct {
      bit         iv;
      bit         ib;
      bit         il;
      bit         rdy;
      bit         e_ov;
      logic [1:0] e_pair;
      bit         e_last;
      bit         e_ir;
   } vec_t;
   vec_t tbl[$];

   function automatic bit bit_at(int j);
      if (j >= 0 && j < fb.size()) return fb[j];
      return 1'b0;
   endfunction

   // Symbol k of the frame as a convolution sum over the generator taps.
   function automatic logic [1:0] sym_at(int k);
      logic c1;
      logic c0;
      c1 = 1'b0;
      c0 = 1'b0;
      for (int t = 0; t < 4; t++) begin
         c1 = c1 ^ (G0[3-t] & bit_at(k - t));
         c0 = c0 ^ (G1[3-t] & bit_at(k - t));
      end
      return {c1, c0};
   endfunction

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void add(bit iv, bit ib, bit il, bit rdy,
                               bit e_ov, logic [1:0] e_pair, bit e_last, bit e_ir);
      vec_t v;
      v.iv = iv; v.ib = ib; v.il = il; v.rdy = rdy;
      v.e_ov = e_ov; v.e_pair = e_pair; v.e_last = e_last; v.e_ir = e_ir;
      tbl.push_back(v);
   endfunction

   function automatic void model_reset();
      fb.delete();
      exp_q.delete();
      mv = 1'b0;
      tail_pending = 0;
   endfunction

   // One clock cycle: drive at the falling edge, check against the model,
   // then advance the model by what the coming rising edge will do.
   task automatic cycle(input bit iv, input bit ib, input bit il, input bit rdy, output bit acc);
      bit         exp_ir;
      bit         load;
      bit         l;
      logic [1:0] s;
      @(negedge clk);
      in_valid  = iv;
      in_bit    = ib;
      in_last   = il;
      out_ready = rdy;
      #1;
      exp_ir = (tail_pending == 0) && (!mv || rdy);
      check("in_ready", 4'(in_ready), 4'(exp_ir));
      check("out_valid", 4'(out_valid), 4'(mv));
      if (mv && exp_q.size() > 0) begin
         check("out_pair", 4'(out_pair), 4'(exp_q[0][2:1]));
         check("out_last", 4'(out_last), 4'(exp_q[0][0]));
      end
      if (mv && rdy && exp_q.size() > 0) void'(exp_q.pop_front());
      acc  = iv && exp_ir;
      load = 1'b0;
      l    = 1'b0;
      s    = 2'b00;
      if (acc) begin
         fb.push_back(ib);
         s    = sym_at(fb.size() - 1);
         l    = TAIL_EN ? 1'b0 : il;
         load = 1'b1;
         if (il) begin
            if (TAIL_EN) tail_pending = 3;
            else         fb.delete();
         end
      end else if (tail_pending > 0 && (!mv || rdy)) begin
         fb.push_back(1'b0);
         s = sym_at(fb.size() - 1);
         tail_pending--;
         l    = (tail_pending == 0);
         load = 1'b1;
         if (l) fb.delete();
      end
      if (load) begin
         exp_q.push_back({s, l});
         mv = 1'b1;
      end else if (rdy) begin
         mv = 1'b0;
      end
   endtask

   task automatic run_table(input string name);
      bit acc;
      for (int i = 0; i < tbl.size(); i++) begin
         cycle(tbl[i].iv, tbl[i].ib, tbl[i].il, tbl[i].rdy, acc);
         check({name, "_valid"}, 4'(out_valid), 4'(tbl[i].e_ov));
         check({name, "_ready"}, 4'(in_ready), 4'(tbl[i].e_ir));
         if (tbl[i].e_ov) begin
            check({name, "_pair"}, 4'(out_pair), 4'(tbl[i].e_pair));
            check({name, "_last"}, 4'(out_last), 4'(tbl[i].e_last));
         end
      end
      tbl.delete();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      bit cur_bit;
      int len;
      int idx;
      int budget;

      // reset values
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", 4'(out_valid), 4'd0);
      check("rst_out_pair", 4'(out_pair), 4'd0);
      check("rst_out_last", 4'(out_last), 4'd0);
      check("rst_in_ready", 4'(in_ready), 4'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // reset mid-frame while a symbol is held
      cycle(1'b1, 1'b1, 1'b0, 1'b1, acc);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, acc);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, acc);
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b0;
      rst_n     = 1'b0;
      #1;
      check("midrst_out_valid", 4'(out_valid), 4'd0);
      check("midrst_out_pair", 4'(out_pair), 4'd0);
      check("midrst_in_ready", 4'(in_ready), 4'd1);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      if (TAIL_EN) begin
         // single-bit frame: 11, 11, 10, 11(last)
         add(1,1,1,1, 0,2'b00,0,1);
         add(0,0,0,1, 1,2'b11,0,0);
         add(0,0,0,1, 1,2'b11,0,0);
         add(0,0,0,1, 1,2'b10,0,0);
         add(0,0,0,1, 1,2'b11,1,1);
         add(0,0,0,1, 0,2'b00,0,1);
         run_table("single");
         // three-bit frame 1,0,1: 11, 11, 01, 00, 10, 11(last)
         add(1,1,0,1, 0,2'b00,0,1);
         add(1,0,0,1, 1,2'b11,0,1);
         add(1,1,1,1, 1,2'b11,0,1);
         add(0,0,0,1, 1,2'b01,0,0);
         add(0,0,0,1, 1,2'b00,0,0);
         add(0,0,0,1, 1,2'b10,0,0);
         add(0,0,0,1, 1,2'b11,1,1);
         add(0,0,0,1, 0,2'b00,0,1);
         run_table("three");
         // back-pressure: 5 stalled cycles after the first symbol
         add(1,1,0,1, 0,2'b00,0,1);
         for (int i = 0; i < 5; i++) add(1,0,0,0, 1,2'b11,0,0);
         add(1,0,0,1, 1,2'b11,0,1);
         add(1,1,1,1, 1,2'b11,0,1);
         add(0,0,0,1, 1,2'b01,0,0);
         add(0,0,0,1, 1,2'b00,0,0);
         add(0,0,0,1, 1,2'b10,0,0);
         add(0,0,0,1, 1,2'b11,1,1);
         add(0,0,0,1, 0,2'b00,0,1);
         run_table("bp");
      end else begin
         // single-bit frame: one symbol carrying out_last
         add(1,1,1,1, 0,2'b00,0,1);
         add(0,0,0,1, 1,2'b11,1,1);
         add(0,0,0,1, 0,2'b00,0,1);
         run_table("single");
         // three-bit frame 1,0,1 then a new frame starting with 1 -> 11
         add(1,1,0,1, 0,2'b00,0,1);
         add(1,0,0,1, 1,2'b11,0,1);
         add(1,1,1,1, 1,2'b11,0,1);
         add(1,1,1,1, 1,2'b01,1,1);
         add(0,0,0,1, 1,2'b11,1,1);
         add(0,0,0,1, 0,2'b00,0,1);
         run_table("three");
         // back-pressure: 5 stalled cycles after the first symbol
         add(1,1,0,1, 0,2'b00,0,1);
         for (int i = 0; i < 5; i++) add(1,0,0,0, 1,2'b11,0,0);
         add(1,0,0,1, 1,2'b11,0,1);
         add(1,1,1,1, 1,2'b11,0,1);
         add(0,0,0,1, 1,2'b01,1,1);
         add(0,0,0,1, 0,2'b00,0,1);
         run_table("bp");
      end

      // random traffic
      for (int f = 0; f < 1000; f++) begin
         len     = $urandom_range(1, 8);
         idx     = 0;
         budget  = 0;
         cur_bit = 1'($urandom_range(0, 1));
         while (idx < len && budget < 400) begin
            cycle(($urandom_range(0, 3) != 0), cur_bit, (idx == len - 1),
                  ($urandom_range(0, 3) != 0), acc);
            if (acc) begin
               idx++;
               cur_bit = 1'($urandom_range(0, 1));
            end
            budget++;
         end
         check("frame_timeout", 4'(idx), 4'(len));
         if (idx < len) break;
      end

      // drain and confirm nothing is left outstanding
      for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, acc);
      check("drain_empty", 4'(exp_q.size()), 4'd0);
      check("drain_out_valid", 4'(out_valid), 4'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
